seq_tx_1011: RTL and testbench

// - Serial frame transmitter paired with the 1011 serial sequence detector: emits sync 1011, then a DATA_W-bit payload MSB first, one bit per clk.
// - Bit-stuffing keeps 1011 out of the payload, so a 1011 detector fires exactly once per frame, on the last sync bit.
// - Sits between a parallel producer (start/ready handshake) and the serial link.

---
 rtl/seq_tx_1011.sv | 165 ++++++++++++++++
 tb/tb_seq_tx_1011.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_tx_1011.sv
// Serial frame transmitter: sync 1011, then a DATA_W-bit payload MSB first, bit-stuffed so 1011 never
// appears outside the sync word. Optional even-parity trailer bit when PARITY_EN is defined.
module seq_tx_1011 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              seq_out,
  output logic              valid_out,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int CW = $clog2(DATA_W) + 1;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t            state, state_nx;
  logic [1:0]        sync_idx, sync_idx_nx;
  logic [CW-1:0]     bit_cnt, bit_cnt_nx;
  logic [2:0]        hist, hist_nx;
  logic              par_sent, par_sent_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic              par_bit, par_bit_nx;
  logic              ready_nx, seq_nx, valid_nx, busy_nx, done_nx;
  logic              emit, bit_val, do_data;

  // The registered state is the state whose bit is currently on seq_out; each edge emits the next bit.
  always_comb begin
    state_nx    = state;
    sync_idx_nx = sync_idx;
    bit_cnt_nx  = bit_cnt;
    hist_nx     = hist;
    par_sent_nx = par_sent;
    shreg_nx    = shreg;
    par_bit_nx  = par_bit;
    emit        = 1'b0;
    bit_val     = 1'b0;
    do_data     = 1'b0;
    done_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          shreg_nx    = data_in;
          par_bit_nx  = even_parity(data_in);
          hist_nx     = 3'b000;
          bit_cnt_nx  = '0;
          sync_idx_nx = 2'd0;
          par_sent_nx = 1'b0;
          emit        = 1'b1;
          bit_val     = 1'b1;
          state_nx    = SYNC;
        end
      end
      SYNC: begin
        if (sync_idx == 2'd3) begin
          state_nx = DATA;
          do_data  = 1'b1;
        end else begin
          emit        = 1'b1;
          bit_val     = (sync_idx != 2'd0);
          sync_idx_nx = sync_idx + 2'd1;
        end
      end
      DATA: do_data = 1'b1;
      PAR: begin
        if (par_sent) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          emit        = 1'b1;
          bit_val     = par_bit;
          par_sent_nx = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (do_data) begin
      if (bit_cnt == CW'(DATA_W)) begin
`ifdef PARITY_EN
        state_nx = PAR;
        emit     = 1'b1;
        if (hist == 3'b101) begin
          bit_val     = 1'b0;
          par_sent_nx = 1'b0;
        end else begin
          bit_val     = par_bit;
          par_sent_nx = 1'b1;
        end
`else
        state_nx = DONE;
        done_nx  = 1'b1;
`endif
      end else if (hist == 3'b101) begin
        // Stuff a 0 so the link never sees 1011; payload position holds.
        emit    = 1'b1;
        bit_val = 1'b0;
      end else begin
        emit       = 1'b1;
        bit_val    = shreg[DATA_W-1];
        shreg_nx   = shreg << 1;
        bit_cnt_nx = bit_cnt + CW'(1);
      end
    end

    if (emit) hist_nx = {hist_nx[1:0], bit_val};

    valid_nx = emit;
    seq_nx   = emit & bit_val;
    ready_nx = (state_nx == IDLE);
    busy_nx  = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sync_idx  <= 2'd0;
      bit_cnt   <= '0;
      hist      <= 3'b000;
      par_sent  <= 1'b0;
      ready     <= 1'b1;
      seq_out   <= 1'b0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      sync_idx  <= sync_idx_nx;
      bit_cnt   <= bit_cnt_nx;
      hist      <= hist_nx;
      par_sent  <= par_sent_nx;
      ready     <= ready_nx;
      seq_out   <= seq_nx;
      valid_out <= valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  // Payload datapath: only meaningful while a frame is in flight, so no reset.
  always_ff @(posedge clk) begin
    shreg   <= shreg_nx;
    par_bit <= par_bit_nx;
  end

  assign state_out = state;

endmodule

// File: tb/tb_seq_tx_1011.sv
// Self-checking bench for seq_tx_1011: table of directed frames plus hand-written abort,
// ignored-start and back-to-back sequences; a 1011 window on seq_out runs every clock.
module tb_seq_tx_1011;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              ready, seq_out, valid_out, busy, done;
  logic [2:0]        state_out;

  seq_tx_1011 #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .ready(ready), .seq_out(seq_out), .valid_out(valid_out),
    .busy(busy), .done(done), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic [31:0] s;
    int          len;
  } vec_t;

  vec_t vecs[6];
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] win = 4'b0;
  int n_match = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance to the next negedge and feed the 1011 detector with what the link shows this cycle.
  task automatic tick();
    logic b;
    @(negedge clk);
    b = seq_out & valid_out;
    win = {win[2:0], b};
    if (win == 4'b1011) n_match++;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [31:0] exp_s, input int exp_len, input string nm);
    int len;
    int m0;
    logic [31:0] got;
    logic seen_done;
    check({nm, " ready_before"}, {31'b0, ready}, 32'd1);
    start = 1'b1;
    data_in = d;
    m0 = n_match;
    len = 0;
    got = '0;
    seen_done = 1'b0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      tick();
      if (i == 0) begin start = 1'b0; data_in = ~d; end
      if (i == 6) start = 1'b1;
      if (i == 7) start = 1'b0;
      if (valid_out) begin got = {got[30:0], seq_out}; len++; end
      if (done) begin
        seen_done = 1'b1;
        check({nm, " done_cycle"}, {27'b0, valid_out, busy, state_out}, {27'b0, 1'b0, 1'b1, 3'd4});
      end
    end
    check({nm, " done_seen"}, {31'b0, seen_done}, 32'd1);
    check({nm, " len"}, len, exp_len);
    check({nm, " stream"}, got, exp_s);
    check({nm, " detect_once"}, n_match - m0, 32'd1);
    tick();
    check({nm, " after_done"}, {29'b0, done, ready, busy}, {29'b0, 1'b0, 1'b1, 1'b0});
    tick();
    check({nm, " no_queued"}, {31'b0, valid_out}, 32'd0);
  endtask

  initial begin
`ifdef PARITY_EN
    vecs[0] = '{8'h00, 32'h1600, 13};
    vecs[1] = '{8'hB4, 32'h5D48, 15};
    vecs[2] = '{8'hAA, 32'h5D28, 15};
    vecs[3] = '{8'hFF, 32'h17FE, 13};
    vecs[4] = '{8'h01, 32'h1603, 13};
    vecs[5] = '{8'h05, 32'h2C14, 14};
`else
    vecs[0] = '{8'h00, 32'h0B00, 12};
    vecs[1] = '{8'hB4, 32'h2EA4, 14};
    vecs[2] = '{8'hAA, 32'h2E94, 14};
    vecs[3] = '{8'hFF, 32'h0BFF, 12};
    vecs[4] = '{8'h01, 32'h0B01, 12};
    vecs[5] = '{8'h05, 32'h0B05, 12};
`endif

    // Reset values while reset is held and just after release.
    tick();
    check("reset_held", {24'b0, ready, seq_out, valid_out, busy, done, state_out}, 32'h80);
    rst = 1'b0;
    tick();
    check("reset_released", {24'b0, ready, seq_out, valid_out, busy, done, state_out}, 32'h80);
    win = 4'b0;

    for (int k = 0; k < 6; k++) begin
      run_frame(vecs[k].d, vecs[k].s, vecs[k].len, $sformatf("vec%0d_%02h", k, vecs[k].d));
    end

    // Abort: start pulsed during DATA is ignored, async reset mid-cycle at the 6th bit.
    begin
      int nv;
      logic any_bad;
      nv = 0;
      start = 1'b1;
      data_in = 8'hFF;
      for (int i = 0; i < 20 && nv < 6; i++) begin
        tick();
        start = 1'b0;
        if (valid_out) nv++;
        if (nv == 5) begin start = 1'b1; data_in = 8'h00; end
      end
      check("abort_reached_bit6", nv, 32'd6);
      check("abort_busy_at_bit6", {30'b0, busy, ready}, {30'b0, 1'b1, 1'b0});
      #2 rst = 1'b1;
      start = 1'b0;
      #1;
      check("abort_async_reset", {24'b0, ready, seq_out, valid_out, busy, done, state_out}, 32'h80);
      tick();
      rst = 1'b0;
      win = 4'b0;
      any_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (done || valid_out || !ready) any_bad = 1'b1;
      end
      check("abort_quiet_after", {31'b0, any_bad}, 32'd0);
    end

    // start held high: frames follow each other with a 2-cycle gap, one detection per frame.
    begin
      int dones, frames, gap, idle_run, m0;
      logic prev_v;
      dones = 0; frames = 0; gap = -1; idle_run = 0; prev_v = 1'b0;
      m0 = n_match;
      start = 1'b1;
      data_in = 8'hB4;
      for (int i = 0; i < 80 && dones < 2; i++) begin
        tick();
        if (valid_out && !prev_v) begin
          frames++;
          if (frames == 2) begin gap = idle_run; start = 1'b0; end
        end
        idle_run = valid_out ? 0 : idle_run + 1;
        if (done) dones++;
        prev_v = valid_out;
      end
      start = 1'b0;
      check("b2b_two_dones", dones, 32'd2);
      check("b2b_gap", gap, 32'd2);
      check("b2b_detect_twice", n_match - m0, 32'd2);
      tick();
      tick();
      check("b2b_idle_after", {30'b0, ready, valid_out}, {30'b0, 1'b1, 1'b0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
